// File: rtl/chaser_sprite_if.sv
// chaser_sprite_if: VGA pixel query and sprite-ROM bus between chaser_sprite and the layer mixer
interface chaser_sprite_if #(parameter int CW = 4, parameter int RW = 5);
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [CW-1:0] rom_col;
  logic [RW-1:0] rom_row;
  logic [11:0] rom_data;
  logic pixel_on;
  logic [11:0] rgb_out;
  modport master (output pix_x, pix_y, rom_data, input rom_col, rom_row, pixel_on, rgb_out);
  modport slave (input pix_x, pix_y, rom_data, output rom_col, rom_row, pixel_on, rgb_out);
endinterface

// File: rtl/chaser_sprite.sv
// chaser_sprite: pursuer sprite that chases a target inside a vertical zone and returns home otherwise
module chaser_sprite #(
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int TARGET_W = 16,
  parameter int TARGET_H = 16,
  parameter int MAX_X = 640,
  parameter int MAX_Y = 480,
  parameter int HOME_X = 620,
  parameter int HOME_Y = 460,
  parameter int ZONE_Y_MIN = 297,
  parameter int STEP = 1,
  parameter int TICK_MAX = 4600000,
  parameter int ANIM_PERIOD = 20000000,
  parameter logic [11:0] TRANSPARENT = 12'h6DE
) (
  input logic clk,
  input logic reset,
  input logic enable,
  input logic [9:0] target_x,
  input logic [9:0] target_y,
  input logic [25:0] speed_offset,
  chaser_sprite_if.slave vid,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [1:0] state,
  output logic hit
);
  localparam int CW = $clog2(SPRITE_W);
  localparam int HW = $clog2(SPRITE_H);
  localparam logic signed [11:0] STP = 12'(STEP);
  localparam logic signed [11:0] X_HI = 12'(MAX_X - SPRITE_W);
  localparam logic signed [11:0] Y_HI = 12'(MAX_Y - SPRITE_H);
  typedef enum logic [1:0] {HOME = 2'b00, CHASE = 2'b01, RET = 2'b10} state_t;
  state_t st, st_n;
  logic [31:0] tcnt, lim, acnt;
  logic tick, in_zone, at_home, move, dir, frame, overlap, in_box, in_box_d, en_d;
  logic [9:0] gx, gy, nx, ny;
  logic [CW-1:0] dx;
  logic [HW-1:0] dy;
  function automatic logic [9:0] approach(input logic [9:0] p, input logic [9:0] g, input logic signed [11:0] hi);
    logic signed [11:0] d, n;
    d = $signed({2'b00, g}) - $signed({2'b00, p});
    n = $signed({2'b00, p}) + (d > STP ? STP : d < -STP ? -STP : d);
    approach = n[11] ? 10'd0 : n > hi ? hi[9:0] : n[9:0];
  endfunction
  // a speed_offset at or above TICK_MAX saturates the period instead of wrapping
  assign lim = {6'd0, speed_offset} >= 32'(TICK_MAX) ? 32'd1 : 32'(TICK_MAX) - {6'd0, speed_offset};
  assign tick = enable && tcnt == lim;
  assign in_zone = target_y >= 10'(ZONE_Y_MIN);
  assign at_home = pos_x == 10'(HOME_X) && pos_y == 10'(HOME_Y);
  assign state = st;
  assign gx = st == CHASE ? target_x : 10'(HOME_X);
  assign gy = st == CHASE ? target_y : 10'(HOME_Y);
  assign nx = approach(pos_x, gx, X_HI);
  assign ny = approach(pos_y, gy, Y_HI);
  assign move = tick && st != HOME;
  always_comb begin
    st_n = st;
    if (enable)
      st_n = in_zone ? CHASE : st == CHASE ? RET : (st == HOME || at_home) ? HOME : RET;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) st <= HOME;
    else st <= st_n;
  assign overlap = {1'b0, pos_x} < {1'b0, target_x} + 11'(TARGET_W) &&
                   {1'b0, target_x} < {1'b0, pos_x} + 11'(SPRITE_W) &&
                   {1'b0, pos_y} < {1'b0, target_y} + 11'(TARGET_H) &&
                   {1'b0, target_y} < {1'b0, pos_y} + 11'(SPRITE_H);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pos_x <= 10'(HOME_X);
      pos_y <= 10'(HOME_Y);
      dir <= 1'b1;
      tcnt <= '0;
      acnt <= '0;
      frame <= 1'b0;
      hit <= 1'b0;
      in_box_d <= 1'b0;
      en_d <= 1'b0;
    end else begin
      hit <= st == CHASE && overlap;
      in_box_d <= in_box;
      en_d <= enable;
      if (enable) begin
        tcnt <= tcnt >= lim ? '0 : tcnt + 32'd1;
        if (move) begin
          pos_x <= nx;
          pos_y <= ny;
          if (nx != pos_x) dir <= nx > pos_x;
        end
        // animation only runs while staying in CHASE; entering or leaving restarts at frame 0
        if (st_n != CHASE || st != CHASE) begin
          acnt <= '0;
          frame <= 1'b0;
        end else if (acnt == 32'(ANIM_PERIOD - 1)) begin
          acnt <= '0;
          frame <= ~frame;
        end else acnt <= acnt + 32'd1;
      end
    end
  assign in_box = vid.pix_x >= pos_x && {1'b0, vid.pix_x} < {1'b0, pos_x} + 11'(SPRITE_W) &&
                  vid.pix_y >= pos_y && {1'b0, vid.pix_y} < {1'b0, pos_y} + 11'(SPRITE_H);
  assign dx = vid.pix_x[CW-1:0] - pos_x[CW-1:0];
  assign dy = vid.pix_y[HW-1:0] - pos_y[HW-1:0];
  assign vid.rom_col = dir ? dx : ~dx;
  assign vid.rom_row = {frame, dy};
  assign vid.pixel_on = in_box_d && en_d && vid.rom_data != TRANSPARENT;
  assign vid.rgb_out = vid.pixel_on ? vid.rom_data : 12'h000;
endmodule

// File: tb/tb_chaser_sprite.sv
// tb_chaser_sprite: randomized scoreboard bench against a behavioural model of the chaser sprite
module tb_chaser_sprite;
  localparam int TM = 10;
  localparam int AP = 8;
  localparam int STEP = 1;
  typedef struct {
    int x, y, st, hit, pix, rgb, dir, fr;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b1;
  logic [9:0] target_x = 10'd600;
  logic [9:0] target_y = 10'd460;
  logic [25:0] speed_offset = 26'd0;
  logic [9:0] pos_x, pos_y;
  logic [1:0] state;
  logic hit;
  int n_chk = 0, n_fail = 0;
  int m_x, m_y, m_dir, m_st, m_tc, m_ac, m_fr;
  exp_t q[$];
  chaser_sprite_if #(.CW(4), .RW(5)) vid ();
  chaser_sprite #(.TICK_MAX(TM), .ANIM_PERIOD(AP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .target_x(target_x), .target_y(target_y),
    .speed_offset(speed_offset), .vid(vid), .pos_x(pos_x), .pos_y(pos_y), .state(state), .hit(hit)
  );
  always #5 clk = ~clk;
  always @(posedge clk) vid.rom_data <= vid.rom_col == 4'd0 ? 12'h6DE : 12'hF00;
  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction
  function automatic int step_to(int p, int g, int hi);
    int d;
    d = g - p;
    d = d > STEP ? STEP : d < -STEP ? -STEP : d;
    return p + d < 0 ? 0 : p + d > hi ? hi : p + d;
  endfunction
  // reference model: updates on each edge from the inputs seen before it and queues what the DUT must show
  always @(posedge clk) begin
    exp_t e;
    int lim, ns, px, py, tx, ty, col;
    bit tk, inb;
    px = vid.pix_x; py = vid.pix_y; tx = target_x; ty = target_y;
    if (!reset) begin
      m_x = 620; m_y = 460; m_dir = 1; m_st = 0; m_tc = 0; m_ac = 0; m_fr = 0;
      e.hit = 0; e.pix = 0;
    end else begin
      inb = px >= m_x && px < m_x + 16 && py >= m_y && py < m_y + 16;
      col = m_dir != 0 ? px - m_x : 15 - (px - m_x);
      e.pix = inb && enable && col != 0;
      e.hit = m_st == 1 && m_x < tx + 16 && tx < m_x + 16 && m_y < ty + 16 && ty < m_y + 16;
      if (enable) begin
        lim = speed_offset >= TM ? 1 : TM - int'(speed_offset);
        tk = m_tc == lim;
        m_tc = tk ? 0 : m_tc + 1;
        ns = ty >= 297 ? 1 : m_st == 0 ? 0 : m_st == 1 ? 2 : (m_x == 620 && m_y == 460) ? 0 : 2;
        if (tk && m_st != 0) begin
          int nx;
          nx = step_to(m_x, m_st == 1 ? tx : 620, 624);
          m_y = step_to(m_y, m_st == 1 ? ty : 460, 464);
          if (nx != m_x) m_dir = nx > m_x ? 1 : 0;
          m_x = nx;
        end
        if (ns != 1 || m_st != 1) begin
          m_ac = 0; m_fr = 0;
        end else if (m_ac == AP - 1) begin
          m_ac = 0; m_fr = 1 - m_fr;
        end else m_ac++;
        m_st = ns;
      end
    end
    e.x = m_x; e.y = m_y; e.st = m_st; e.dir = m_dir; e.fr = m_fr;
    e.rgb = e.pix != 0 ? 'hF00 : 0;
    q.push_back(e);
  end
  always @(negedge clk) if (q.size() > 0) begin
    exp_t e;
    int px, py;
    e = q.pop_front();
    chk("pos_x", pos_x, e.x);
    chk("pos_y", pos_y, e.y);
    chk("state", state, e.st);
    chk("hit", hit, e.hit);
    chk("pixel_on", vid.pixel_on, e.pix);
    chk("rgb_out", vid.rgb_out, e.rgb);
    px = vid.pix_x; py = vid.pix_y;
    if (px >= e.x && px < e.x + 16 && py >= e.y && py < e.y + 16) begin
      chk("rom_col", vid.rom_col, e.dir != 0 ? px - e.x : 15 - (px - e.x));
      chk("rom_row", vid.rom_row, e.fr * 16 + py - e.y);
    end
  end
  task automatic cyc();
    int px, py;
    @(posedge clk);
    #1;
    px = $urandom_range(0, 7) == 0 ? $urandom_range(0, 1023) : m_x - 3 + $urandom_range(0, 21);
    py = $urandom_range(0, 7) == 0 ? $urandom_range(0, 1023) : m_y - 3 + $urandom_range(0, 21);
    vid.pix_x = 10'(px < 0 ? 0 : px > 1023 ? 1023 : px);
    vid.pix_y = 10'(py < 0 ? 0 : py > 1023 ? 1023 : py);
  endtask
  task automatic do_reset(input logic [25:0] so);
    @(negedge clk);
    #1;
    reset = 1'b0;
    speed_offset = so;
    repeat (2) cyc();
    reset = 1'b1;
  endtask
  initial begin
    vid.pix_x = 10'd0;
    vid.pix_y = 10'd0;
    repeat (3) cyc();
    reset = 1'b1;
    repeat (260) cyc();
    target_x = 10'(m_x + 15); target_y = 10'(m_y);
    repeat (3) cyc();
    target_x = 10'(m_x + 16);
    repeat (3) cyc();
    target_x = 10'(m_x); target_y = 10'(m_y + 15);
    repeat (3) cyc();
    target_y = 10'(m_y + 16);
    repeat (3) cyc();
    enable = 1'b0;
    repeat (20) cyc();
    enable = 1'b1;
    do_reset(26'd4600005);
    target_x = 10'($urandom_range(0, 639));
    target_y = 10'($urandom_range(297, 479));
    repeat (300) cyc();
    target_y = 10'd200;
    for (int i = 0; i < 2000 && m_st != 0; i++) cyc();
    repeat (10) cyc();
    for (int k = 0; k < 60; k++) begin
      if (k % 10 == 0) begin
        int sel;
        sel = $urandom_range(0, 3);
        do_reset(sel == 0 ? 26'd0 : sel == 1 ? 26'($urandom_range(0, 12)) : sel == 2 ? 26'd4600005 : 26'h3FFFFFF);
      end
      target_x = 10'($urandom_range(0, 1023));
      target_y = 10'($urandom_range(150, 479));
      repeat ($urandom_range(20, 80)) begin
        enable = $urandom_range(0, 9) != 0;
        cyc();
      end
    end
    enable = 1'b1;
    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
